// File: rtl/aes_key_sched_ctrl.sv
// Key schedule controller: accepts a cipher key, pulses the expander, captures NR+1 round keys.
// Reads return one cycle after request; loads are held off while expanding or while cipher_busy.
module aes_key_sched_ctrl #(
    parameter int NR      = 10,
    parameter int KEY_W   = 128,
    parameter int TIMEOUT = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             key_load_valid,
    input  logic [KEY_W-1:0] key_load_data,
    output logic             key_load_ready,
    input  logic             cipher_busy,
    output logic             ke_start,
    output logic [KEY_W-1:0] ke_key,
    input  logic             ke_valid,
    input  logic [3:0]       ke_round,
    input  logic [KEY_W-1:0] ke_round_key,
    input  logic             rk_rd_en,
    input  logic [3:0]       rk_rd_idx,
    output logic [KEY_W-1:0] rk_rd_data,
    output logic             rk_rd_valid,
    output logic             keys_ready,
    output logic             busy,
    output logic             err_timeout
);

    localparam int         CW       = $clog2(TIMEOUT + 1);
    localparam logic [3:0] LAST_IDX = 4'(NR);

    typedef enum logic [1:0] {S_IDLE, S_LAUNCH, S_COLLECT, S_READY} state_t;

    state_t           r_state, w_state_nxt;
    logic [KEY_W-1:0] r_table [0:NR];
    logic [NR:0]      r_mask, w_mask_nxt;
    logic [CW-1:0]    r_tmo_cnt;
    logic [KEY_W-1:0] r_ke_key, r_rd_data;
    logic             r_rd_valid, r_err_timeout;
    logic             w_load_window, w_accept, w_collect, w_ke_hit, w_timeout, w_rd_ok;

    assign w_accept   = key_load_valid && w_load_window && !cipher_busy;
    assign w_collect  = (r_state == S_COLLECT);
    assign w_ke_hit   = w_collect && ke_valid && (ke_round <= LAST_IDX);
    assign w_timeout  = w_collect && !ke_valid && (r_tmo_cnt == CW'(TIMEOUT - 1));
    assign w_rd_ok    = rk_rd_en && (r_state == S_READY) && (rk_rd_idx <= LAST_IDX);

    // Ready is forced low while in reset so every output reads zero during reset.
    assign key_load_ready = rst_n && w_load_window && !cipher_busy;
    assign ke_key         = r_ke_key;
    assign rk_rd_data     = r_rd_data;
    assign rk_rd_valid    = r_rd_valid;
    assign err_timeout    = r_err_timeout;

    always_comb begin
        w_mask_nxt = r_mask;
        if (w_ke_hit) begin
            w_mask_nxt[ke_round] = 1'b1;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        ke_start      = 1'b0;
        busy          = 1'b0;
        keys_ready    = 1'b0;
        w_load_window = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_load_window = 1'b1;
                if (w_accept) w_state_nxt = S_LAUNCH;
            end
            S_LAUNCH: begin
                ke_start    = 1'b1;
                busy        = 1'b1;
                w_state_nxt = S_COLLECT;
            end
            S_COLLECT: begin
                busy = 1'b1;
                if (&w_mask_nxt)    w_state_nxt = S_READY;
                else if (w_timeout) w_state_nxt = S_IDLE;
            end
            S_READY: begin
                keys_ready    = 1'b1;
                w_load_window = 1'b1;
                if (w_accept) w_state_nxt = S_LAUNCH;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= S_IDLE;
            r_ke_key      <= '0;
            r_mask        <= '0;
            r_tmo_cnt     <= '0;
            r_err_timeout <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_accept) begin
                r_ke_key      <= key_load_data;
                r_mask        <= '0;
                r_err_timeout <= 1'b0;
            end else if (w_timeout) begin
                r_err_timeout <= 1'b1;
                r_mask        <= '0;
            end else begin
                r_mask <= w_mask_nxt;
            end
            // Out-of-range rounds still count as expander activity.
            if ((r_state == S_LAUNCH) || (w_collect && ke_valid)) begin
                r_tmo_cnt <= '0;
            end else if (w_collect) begin
                r_tmo_cnt <= r_tmo_cnt + CW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i <= NR; i++) r_table[i] <= '0;
        end else if (w_ke_hit) begin
            r_table[ke_round] <= ke_round_key;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_valid <= 1'b0;
            r_rd_data  <= '0;
        end else begin
            r_rd_valid <= w_rd_ok;
            r_rd_data  <= w_rd_ok ? r_table[rk_rd_idx] : '0;
        end
    end

endmodule

// File: tb/tb_aes_key_sched_ctrl.sv
// Self-checking bench for aes_key_sched_ctrl: stub expander, table vectors and a scoreboard model.
module tb_aes_key_sched_ctrl;
    localparam int NR      = 10;
    localparam int KEY_W   = 128;
    localparam int TIMEOUT = 64;

    logic             clk;
    logic             rst_n;
    logic             key_load_valid;
    logic [KEY_W-1:0] key_load_data;
    logic             key_load_ready;
    logic             cipher_busy;
    logic             ke_start;
    logic [KEY_W-1:0] ke_key;
    logic             ke_valid;
    logic [3:0]       ke_round;
    logic [KEY_W-1:0] ke_round_key;
    logic             rk_rd_en;
    logic [3:0]       rk_rd_idx;
    logic [KEY_W-1:0] rk_rd_data;
    logic             rk_rd_valid;
    logic             keys_ready;
    logic             busy;
    logic             err_timeout;

    aes_key_sched_ctrl #(.NR(NR), .KEY_W(KEY_W), .TIMEOUT(TIMEOUT)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .key_load_valid (key_load_valid),
        .key_load_data  (key_load_data),
        .key_load_ready (key_load_ready),
        .cipher_busy    (cipher_busy),
        .ke_start       (ke_start),
        .ke_key         (ke_key),
        .ke_valid       (ke_valid),
        .ke_round       (ke_round),
        .ke_round_key   (ke_round_key),
        .rk_rd_en       (rk_rd_en),
        .rk_rd_idx      (rk_rd_idx),
        .rk_rd_data     (rk_rd_data),
        .rk_rd_valid    (rk_rd_valid),
        .keys_ready     (keys_ready),
        .busy           (busy),
        .err_timeout    (err_timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic             en;
        logic [3:0]       idx;
        logic             exp_vld;
        logic [KEY_W-1:0] exp_dat;
    } rd_vec_t;

    int               total = 0;
    int               bad   = 0;
    logic [KEY_W-1:0] fips_rk [0:NR];
    logic [KEY_W-1:0] src_rk  [0:NR];
    logic [KEY_W-1:0] m_tbl   [0:NR];
    bit               m_seen  [0:NR];
    bit               m_valid;
    rd_vec_t          vecs[$];

    task automatic chk(input string name, input logic [KEY_W-1:0] act, input logic [KEY_W-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [KEY_W-1:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    function automatic bit all_seen();
        for (int i = 0; i <= NR; i++) if (!m_seen[i]) return 1'b0;
        return 1'b1;
    endfunction

    task automatic load_key(input logic [KEY_W-1:0] k, input bit rd, input logic [3:0] rd_idx,
                            input logic [KEY_W-1:0] rd_exp);
        key_load_valid = 1'b1;
        key_load_data  = k;
        rk_rd_en       = rd;
        rk_rd_idx      = rd_idx;
        #1;
        chk("load_ready", key_load_ready, 1);
        step();
        key_load_valid = 1'b0;
        for (int i = 0; i <= NR; i++) m_seen[i] = 1'b0;
        m_valid = 1'b0;
        chk("ke_start_pulse", ke_start, 1);
        chk("ke_key", ke_key, k);
        chk("busy_launch", busy, 1);
        chk("keys_ready_launch", keys_ready, 0);
        chk("err_clear_on_load", err_timeout, 0);
        if (rd) begin
            chk("rd_during_load_vld", rk_rd_valid, 1);
            chk("rd_during_load_old_dat", rk_rd_data, rd_exp);
        end
        step();
        chk("ke_start_once", ke_start, 0);
        chk("busy_collect", busy, 1);
        chk("load_ready_collect", key_load_ready, 0);
        if (rd) chk("rd_after_rekey_vld", rk_rd_valid, 0);
        rk_rd_en = 1'b0;
    endtask

    task automatic send_round(input logic [3:0] r, input logic [KEY_W-1:0] d);
        ke_valid     = 1'b1;
        ke_round     = r;
        ke_round_key = d;
        step();
        ke_valid = 1'b0;
        if (r <= 4'(NR)) begin
            m_tbl[r]  = d;
            m_seen[r] = 1'b1;
        end
        m_valid = all_seen();
        chk($sformatf("keys_ready_after_round%0d", r), keys_ready, m_valid);
    endtask

    task automatic idle(input int n);
        ke_valid = 1'b0;
        for (int i = 0; i < n; i++) begin
            step();
            chk("keys_ready_idle", keys_ready, m_valid);
        end
    endtask

    // Random order, junk indices, gaps and overwrites with garbage, until every slot is filled.
    task automatic feed_random();
        int q[$];
        int pick;
        for (int it = 0; it < 400 && !m_valid; it++) begin
            pick = $urandom_range(0, 99);
            if (pick < 20) begin
                idle(1);
            end else if (pick < 30) begin
                send_round(4'($urandom_range(NR + 1, 15)), rnd128());
            end else if (pick < 45) begin
                send_round(4'($urandom_range(0, NR)), rnd128());
            end else begin
                q.delete();
                for (int i = 0; i <= NR; i++) if (!m_seen[i]) q.push_back(i);
                if (q.size() > 0) begin
                    pick = q[$urandom_range(0, q.size() - 1)];
                    send_round(4'(pick), src_rk[pick]);
                end
            end
        end
        chk("feed_complete", keys_ready, 1);
    endtask

    task automatic model_reads();
        rd_vec_t v;
        vecs.delete();
        for (int i = 0; i < 16; i++) begin
            v.en      = 1'b1;
            v.idx     = 4'(i);
            v.exp_vld = m_valid && (i <= NR);
            v.exp_dat = '0;
            if (v.exp_vld) v.exp_dat = m_tbl[i];
            vecs.push_back(v);
        end
        v.en = 1'b0; v.idx = 4'd3; v.exp_vld = 1'b0; v.exp_dat = '0;
        vecs.push_back(v);
    endtask

    task automatic run_reads(input string tag);
        foreach (vecs[i]) begin
            rk_rd_en  = vecs[i].en;
            rk_rd_idx = vecs[i].idx;
            step();
            chk($sformatf("%s_vld_idx%0d_en%0d", tag, vecs[i].idx, vecs[i].en), rk_rd_valid, vecs[i].exp_vld);
            chk($sformatf("%s_dat_idx%0d_en%0d", tag, vecs[i].idx, vecs[i].en), rk_rd_data, vecs[i].exp_dat);
        end
        rk_rd_en = 1'b0;
    endtask

    initial begin
        int      cyc;
        bit      hit;
        rd_vec_t v;
        logic [KEY_W-1:0] old_rk1;

        fips_rk[0]  = 128'h000102030405060708090a0b0c0d0e0f;
        fips_rk[1]  = 128'hd6aa74fdd2af72fadaa678f1d6ab76fe;
        fips_rk[2]  = 128'hb692cf0b643dbdf1be9bc5006830b3fe;
        fips_rk[3]  = 128'hb6ff744ed2c2c9bf6c590cbf0469bf41;
        fips_rk[4]  = 128'h47f7f7bc95353e03f96c32bcfd058dfd;
        fips_rk[5]  = 128'h3caaa3e8a99f9deb50f3af57adf622aa;
        fips_rk[6]  = 128'h5e390f7df7a69296a7553dc10aa31f6b;
        fips_rk[7]  = 128'h14f9701ae35fe28c440adf4d4ea9c026;
        fips_rk[8]  = 128'h47438735a41c65b9e016baf4aebf7ad2;
        fips_rk[9]  = 128'h549932d1f08557681093ed9cbe2c974e;
        fips_rk[10] = 128'h13111d7fe3944a17f307a78b4d2b30c5;
        for (int i = 0; i <= NR; i++) begin
            m_tbl[i]  = '0;
            m_seen[i] = 1'b0;
        end
        m_valid = 1'b0;

        rst_n = 1'b0; key_load_valid = 1'b0; key_load_data = '0; cipher_busy = 1'b0;
        ke_valid = 1'b0; ke_round = '0; ke_round_key = '0; rk_rd_en = 1'b0; rk_rd_idx = '0;

        #2;
        chk("rst_key_load_ready", key_load_ready, 0);
        chk("rst_ke_start", ke_start, 0);
        chk("rst_ke_key", ke_key, 0);
        chk("rst_rd_valid", rk_rd_valid, 0);
        chk("rst_rd_data", rk_rd_data, 0);
        chk("rst_keys_ready", keys_ready, 0);
        chk("rst_busy", busy, 0);
        chk("rst_err", err_timeout, 0);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        step();
        chk("idle_load_ready", key_load_ready, 1);
        chk("idle_busy", busy, 0);

        // Known FIPS-197 schedule delivered in order with short gaps.
        load_key(fips_rk[0], 1'b0, 4'd0, '0);
        for (int r = 0; r <= NR; r++) begin
            idle($urandom_range(0, 2));
            send_round(4'(r), fips_rk[r]);
        end

        // Back-to-back reads of every index, then out-of-range and idle requests.
        vecs.delete();
        for (int i = 0; i <= NR; i++) begin
            v.en = 1'b1; v.idx = 4'(i); v.exp_vld = 1'b1; v.exp_dat = fips_rk[i];
            vecs.push_back(v);
        end
        v.en = 1'b1; v.idx = 4'd11; v.exp_vld = 1'b0; v.exp_dat = '0; vecs.push_back(v);
        v.en = 1'b1; v.idx = 4'd15; v.exp_vld = 1'b0; v.exp_dat = '0; vecs.push_back(v);
        v.en = 1'b0; v.idx = 4'd1;  v.exp_vld = 1'b0; v.exp_dat = '0; vecs.push_back(v);
        v.en = 1'b1; v.idx = 4'd10; v.exp_vld = 1'b1; v.exp_dat = 128'h13111d7fe3944a17f307a78b4d2b30c5;
        vecs.push_back(v);
        v.en = 1'b0; v.idx = 4'd10; v.exp_vld = 1'b0; v.exp_dat = '0; vecs.push_back(v);
        run_reads("fips");

        // Load blocked by cipher_busy in READY.
        cipher_busy = 1'b1; key_load_valid = 1'b1; key_load_data = '1;
        #1;
        chk("busy_blocks_ready", key_load_ready, 0);
        step();
        chk("busy_no_reload_kr", keys_ready, 1);
        chk("busy_no_reload_start", ke_start, 0);
        chk("busy_no_reload_key", ke_key, fips_rk[0]);
        key_load_valid = 1'b0;
        cipher_busy    = 1'b0;

        // Rekey with all-ones while reading slot 1 in the same cycle.
        old_rk1 = m_tbl[1];
        for (int i = 0; i <= NR; i++) src_rk[i] = rnd128();
        load_key('1, 1'b1, 4'd1, old_rk1);
        feed_random();
        model_reads();
        run_reads("rekey");

        // Expander stalls after round 4.
        for (int i = 0; i <= NR; i++) src_rk[i] = rnd128();
        load_key(rnd128(), 1'b0, 4'd0, '0);
        for (int r = 0; r <= 4; r++) send_round(4'(r), src_rk[r]);
        hit = 1'b0;
        cyc = 0;
        for (int n = 1; n <= TIMEOUT + 4 && !hit; n++) begin
            step();
            if (err_timeout === 1'b1) begin
                hit = 1'b1;
                cyc = n;
            end
        end
        chk("timeout_cycles", 128'(cyc), 128'(TIMEOUT));
        chk("timeout_busy", busy, 0);
        chk("timeout_idle_ready", key_load_ready, 1);
        chk("timeout_keys_ready", keys_ready, 0);
        m_valid = 1'b0;
        idle(3);
        chk("timeout_sticky", err_timeout, 1);
        model_reads();
        run_reads("timeout");
        load_key(rnd128(), 1'b0, 4'd0, '0);
        feed_random();
        model_reads();
        run_reads("after_timeout");

        // Reset mid-COLLECT.
        for (int i = 0; i <= NR; i++) src_rk[i] = rnd128();
        load_key(rnd128(), 1'b0, 4'd0, '0);
        for (int r = 0; r <= 2; r++) send_round(4'(r), src_rk[r]);
        rst_n = 1'b0;
        #1;
        chk("arst_key_load_ready", key_load_ready, 0);
        chk("arst_ke_start", ke_start, 0);
        chk("arst_ke_key", ke_key, 0);
        chk("arst_rd_valid", rk_rd_valid, 0);
        chk("arst_rd_data", rk_rd_data, 0);
        chk("arst_keys_ready", keys_ready, 0);
        chk("arst_busy", busy, 0);
        chk("arst_err", err_timeout, 0);
        for (int i = 0; i <= NR; i++) begin
            m_tbl[i]  = '0;
            m_seen[i] = 1'b0;
        end
        m_valid = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        step();
        model_reads();
        run_reads("post_reset");
        load_key(rnd128(), 1'b0, 4'd0, '0);
        feed_random();
        model_reads();
        run_reads("post_reset_reload");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
